// File: rtl/crypt_mode_framer.sv
// rtl/crypt_mode_framer.sv - byte-to-block framer with PKCS#7 padding and ECB/CBC chaining
module crypt_mode_framer #(
    parameter int BLOCK_BYTES = 8,
    parameter bit PAD_ENABLE  = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       mode_cbc,
    input  logic [8*BLOCK_BYTES-1:0]   iv,
    input  logic [7:0]                 s_axis_tdata,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic                       s_axis_tlast,
    output logic [8*BLOCK_BYTES-1:0]   c_m_axis_tdata,
    output logic                       c_m_axis_tvalid,
    input  logic                       c_m_axis_tready,
    input  logic [8*BLOCK_BYTES-1:0]   c_s_axis_tdata,
    input  logic                       c_s_axis_tvalid,
    output logic                       c_s_axis_tready,
    output logic [7:0]                 m_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast,
    output logic                       busy
);
    localparam int BW = 8 * BLOCK_BYTES;
    localparam int CW = $clog2(BLOCK_BYTES);

    typedef enum logic [2:0] {ASSEMBLE, PAD, ISSUE, WAIT_CT, EMIT} state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic [CW-1:0]   out_idx;
    logic [BW-1:0]   blk;
    logic [BW-1:0]   chain;
    logic [BW-1:0]   shreg;
    logic            cbc;
    logic            msg_start;
    logic            last_blk;
    logic            pad_pending;
    logic            s_rdy;
    logic            c_m_valid;
    logic [BW-1:0]   c_m_data;
    logic            c_s_rdy;
    logic            m_valid;
    logic            m_last;

    logic [7:0]      pad_byte;
    logic [BW-1:0]   asm_blk;
    logic [BW-1:0]   pad_blk;
    logic            cbc_eff;
    logic [BW-1:0]   chain_eff;
    logic [BW-1:0]   asm_ct;
    logic            last_byte;
    logic            out_final;

    // The first byte of a message must see the freshly sampled mode/iv, not the stale chain.
    always_comb begin
        pad_byte  = PAD_ENABLE ? 8'(BLOCK_BYTES - 1 - int'(count)) : 8'h00;
        asm_blk   = blk;
        pad_blk   = '0;
        for (int i = 0; i < BLOCK_BYTES; i++) begin
            pad_blk[8*i +: 8] = 8'(BLOCK_BYTES);
            if (i == int'(count))
                asm_blk[8*i +: 8] = s_axis_tdata;
            else if (s_axis_tlast && i > int'(count))
                asm_blk[8*i +: 8] = pad_byte;
        end
        cbc_eff   = msg_start ? mode_cbc : cbc;
        chain_eff = msg_start ? (mode_cbc ? iv : '0) : chain;
        asm_ct    = cbc_eff ? (asm_blk ^ chain_eff) : asm_blk;
        last_byte = (count == CW'(BLOCK_BYTES - 1));
        out_final = (out_idx == CW'(BLOCK_BYTES - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ASSEMBLE;
            count       <= '0;
            out_idx     <= '0;
            blk         <= '0;
            chain       <= '0;
            shreg       <= '0;
            cbc         <= 1'b0;
            msg_start   <= 1'b1;
            last_blk    <= 1'b0;
            pad_pending <= 1'b0;
            s_rdy       <= 1'b0;
            c_m_valid   <= 1'b0;
            c_m_data    <= '0;
            c_s_rdy     <= 1'b0;
            m_valid     <= 1'b0;
            m_last      <= 1'b0;
        end else begin
            case (state)
                ASSEMBLE: begin
                    s_rdy <= 1'b1;
                    if (s_rdy && s_axis_tvalid) begin
                        blk <= asm_blk;
                        if (msg_start) begin
                            cbc       <= mode_cbc;
                            chain     <= mode_cbc ? iv : '0;
                            msg_start <= 1'b0;
                        end
                        if (s_axis_tlast || last_byte) begin
                            s_rdy     <= 1'b0;
                            c_m_valid <= 1'b1;
                            c_m_data  <= asm_ct;
                            state     <= ISSUE;
                            if (s_axis_tlast && last_byte && PAD_ENABLE)
                                pad_pending <= 1'b1;
                            else if (s_axis_tlast)
                                last_blk <= 1'b1;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                PAD: begin
                    blk       <= pad_blk;
                    c_m_data  <= cbc ? (pad_blk ^ chain) : pad_blk;
                    c_m_valid <= 1'b1;
                    state     <= ISSUE;
                end
                ISSUE: begin
                    if (c_m_axis_tready) begin
                        c_m_valid <= 1'b0;
                        c_s_rdy   <= 1'b1;
                        state     <= WAIT_CT;
                    end
                end
                WAIT_CT: begin
                    if (c_s_axis_tvalid) begin
                        shreg   <= c_s_axis_tdata;
                        if (cbc)
                            chain <= c_s_axis_tdata;
                        c_s_rdy <= 1'b0;
                        m_valid <= 1'b1;
                        m_last  <= 1'b0;
                        out_idx <= '0;
                        state   <= EMIT;
                    end
                end
                EMIT: begin
                    if (m_axis_tready) begin
                        if (out_final) begin
                            m_valid <= 1'b0;
                            m_last  <= 1'b0;
                            if (pad_pending) begin
                                pad_pending <= 1'b0;
                                last_blk    <= 1'b1;
                                state       <= PAD;
                            end else begin
                                if (last_blk) begin
                                    last_blk  <= 1'b0;
                                    msg_start <= 1'b1;
                                end
                                count <= '0;
                                s_rdy <= 1'b1;
                                state <= ASSEMBLE;
                            end
                        end else begin
                            shreg   <= shreg >> 8;
                            out_idx <= out_idx + 1'b1;
                            m_last  <= last_blk && (out_idx == CW'(BLOCK_BYTES - 2));
                        end
                    end
                end
                default: state <= ASSEMBLE;
            endcase
        end
    end

    assign s_axis_tready   = s_rdy;
    assign c_m_axis_tdata  = c_m_data;
    assign c_m_axis_tvalid = c_m_valid;
    assign c_s_axis_tready = c_s_rdy;
    assign m_axis_tdata    = shreg[7:0];
    assign m_axis_tvalid   = m_valid;
    assign m_axis_tlast    = m_last;
    assign busy            = !(state == ASSEMBLE && count == '0 && msg_start);

endmodule

// File: doc/crypt_mode_framer.md
Name: crypt_mode_framer

Overview:
Byte-stream framer for the block cipher core in the UART crypto datapath. It packs AXI-Stream bytes into BLOCK_BYTES-wide blocks, applies PKCS#7 padding at tlast, and chains blocks in ECB or CBC mode. It exchanges one block at a time with the cipher over AXI-Stream and serializes each ciphertext block back to bytes, with tlast on the final byte of the message. It replaces the fixed 8→64 / 64→8 width-adapter pair, adding message framing, padding and chaining.

Parameters:
BLOCK_BYTES, 8, cipher block size in bytes; legal range 2..32. BLOCK_W = 8*BLOCK_BYTES.
PAD_ENABLE, 1, 1 = PKCS#7 padding; 0 = zero-fill a partial last block and never add an extra block.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
mode_cbc  in  1  0 = ECB, 1 = CBC; sampled when the first byte of a message is accepted
iv  in  BLOCK_W  CBC initial chain value; sampled with mode_cbc
s_axis_tdata  in  8  plaintext byte
s_axis_tvalid  in  1  plaintext valid
s_axis_tready  out  1  plaintext ready
s_axis_tlast  in  1  last byte of the message
c_m_axis_tdata  out  BLOCK_W  block sent to the cipher
c_m_axis_tvalid  out  1  block valid
c_m_axis_tready  in  1  cipher ready
c_s_axis_tdata  in  BLOCK_W  ciphertext block from the cipher
c_s_axis_tvalid  in  1  ciphertext valid
c_s_axis_tready  out  1  ciphertext ready
m_axis_tdata  out  8  ciphertext byte
m_axis_tvalid  out  1  ciphertext byte valid
m_axis_tready  in  1  downstream ready
m_axis_tlast  out  1  last byte of the message
busy  out  1  high whenever the FSM is not in ASSEMBLE with byte count 0 and msg_start set

Behaviour:
- Reset: asynchronous on rst_n low. The FSM enters ASSEMBLE; byte count, block register, chain register and flags clear; msg_start = 1.
- Reset output values: all tvalid/tready outputs 0, except s_axis_tready = 1 one cycle after reset release. m_axis_tlast = 0, busy = 0. Data outputs are 0.
- Byte order: the first byte received lands in bits [7:0]. On output, bits [7:0] are sent first.
- Handshakes: a transfer occurs only when valid and ready are both high. Data, valid and last stay stable while valid is high and ready is low.
- FSM states: ASSEMBLE, PAD, ISSUE, WAIT_CT, EMIT.
- ASSEMBLE: s_axis_tready = 1. Each accepted byte is written at position count, and count increments.
  - If msg_start = 1, latch mode_cbc and iv into the chain register (iv used only when CBC), then clear msg_start.
  - Byte fills the block (count = BLOCK_BYTES-1) and tlast = 0 → ISSUE.
  - tlast with a partial block (n bytes, n < BLOCK_BYTES), PAD_ENABLE = 1: fill the remaining bytes with BLOCK_BYTES-n. Set last_blk → ISSUE.
  - Same case with PAD_ENABLE = 0: fill with 0x00, set last_blk → ISSUE.
  - tlast completing a full block: with PAD_ENABLE = 1, set pad_pending; with PAD_ENABLE = 0, set last_blk. Then → ISSUE.
- ISSUE: c_m_axis_tvalid = 1 and c_m_axis_tdata = block XOR chain (CBC) or block (ECB), held stable until c_m_axis_tready. On the handshake → WAIT_CT.
- WAIT_CT: c_s_axis_tready = 1. On the handshake, latch the ciphertext into the output shift register. In CBC, chain ← ciphertext. → EMIT.
- EMIT: send BLOCK_BYTES bytes, one per m_axis handshake.
  - m_axis_tlast = 1 only on the final byte when last_blk is set.
  - After the final byte: if pad_pending, clear it, set last_blk → PAD.
  - Else if last_blk, clear it, set msg_start → ASSEMBLE.
  - Else → ASSEMBLE.
  - count clears on the EMIT → ASSEMBLE transition.
- PAD: load a block of all bytes = BLOCK_BYTES in one cycle → ISSUE.
- Throughput: one block is in flight at a time. s_axis_tready is low in PAD, ISSUE, WAIT_CT and EMIT.
- Simultaneous events: none are possible across interfaces, because each state owns exactly one handshake.
- Reset mid-operation: any partial block, the pending ciphertext and the chain are discarded, and the next accepted byte starts a new message.
- An unexpected c_s_axis_tvalid outside WAIT_CT is ignored (not consumed).

Test Plan:
(Cipher stub: ciphertext = plaintext XOR all-ones, 1-cycle latency; BLOCK_BYTES = 8.)
1. ECB, PAD_ENABLE = 1, bytes 00..07 with tlast on 07 → cipher sees 64'h0706050403020100, then 64'h0808080808080808. Output is FF,FE,…,F8 then F7×8, with tlast only on the 16th byte.
2. ECB, bytes AA,BB,CC with tlast → cipher sees 64'h0505050505CCBBAA. Output is 55,44,33 then FA×5, with tlast on the 8th byte.
3. CBC, iv = 64'h1111111111111111, bytes 00..0F with tlast → cipher sees 64'h1617141512131011, then 64'hE6E6E6E6E6E6E6E6, then 64'h1111111111111111. Output is 24 bytes.
4. Backpressure: m_axis_tready and c_m_axis_tready toggle pseudo-randomly → output byte stream identical to scenario 1. Data, valid and last stay stable while stalled, and no bytes are lost or duplicated.
5. PAD_ENABLE = 0, bytes 01,02 with tlast → cipher sees 64'h0000000000000201. Exactly 8 output bytes, tlast on the 8th.
6. Assert rst_n low in WAIT_CT → all valids 0 and busy 0 immediately. After release, message 00..07 produces exactly the scenario 1 output.
